// File: rtl/sram_bus_arbiter_pkg.sv
// sram_bus_arbiter_pkg
//   Shared encodings for the IF/EX SRAM-like bus arbiter. It holds the
//   arbiter state type, the transfer size and owner encodings, and the
//   alignment rule that the arbiter and the store aligner both use.
package sram_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    // Size 3 is reserved. It is reported as misaligned, so it never reaches the bus.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/sram_bus_arbiter_store_align.sv
// sram_bus_arbiter_store_align
//   Combinational store formatting for the data requester.
//   Ports:
//     size          in  2   0 byte, 1 half, 2 word, 3 reserved
//     addr_lo       in  2   byte offset within the word
//     wr            in  1   1 = store (enables byte strobes)
//     wdata         in  32  right-justified store data
//     wstrb         out 4   byte enables (all zero for loads)
//     wdata_aligned out 32  store data replicated across the lanes
//     misaligned    out 1   access cannot be issued on the bus
module sram_bus_arbiter_store_align
    import sram_bus_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_aligned,
    output logic        misaligned
);

    always_comb begin
        wstrb         = 4'b0000;
        wdata_aligned = wdata;
        misaligned    = is_misaligned(size, addr_lo);
        case (size)
            SZ_BYTE: begin
                // Replicating the data lets the slave pick the lane from wstrb alone.
                wdata_aligned = {4{wdata[7:0]}};
                if (wr) wstrb = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                wdata_aligned = {2{wdata[15:0]}};
                if (wr) wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                if (wr) wstrb = 4'b1111;
            end
            default: begin
                wstrb = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
//   Shares one SRAM-like bus between instruction fetch (inst_*) and the
//   load/store path (data_*). Each transfer passes through an address phase
//   and then a data phase. Data requests have priority. However, once
//   MAX_DATA_STREAK data grants have been made while a fetch was waiting,
//   the next grant goes to the fetch.
//
//   Handshake semantics (for every request and bus signal below):
//     A requester raises *_req together with stable attributes. It holds them
//     until its *_done pulse and drops req in the following cycle. On the bus,
//     bus_req together with its attributes is valid and held stable until the
//     cycle in which bus_addr_ok is high (this is the address transfer).
//     bus_data_ok completes the data phase. It is accepted only after the
//     address transfer has happened and is ignored at all other times.
//
//   Ports:
//     clk, resetn                     core clock, synchronous active-low reset
//     inst_req/addr -> rdata/done     fetch requester
//     data_req/wr/size/addr/wdata     load/store requester
//       -> data_rdata/done/err
//     stallreq                        pipeline stall request
//     bus_req/wr/size/addr/wstrb/wdata, bus_addr_ok/data_ok/rdata
//                                     SRAM-like master interface
//     dbg_state                       current arbiter state
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_done,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_done,
    output logic        data_err,
    output logic        stallreq,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  dbg_state
);

    localparam int SW = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    arb_state_e  state_q, state_d;
    logic        owner_q;
    logic [31:0] lat_addr_q;
    logic        lat_wr_q;
    logic [1:0]  lat_size_q;
    logic [3:0]  lat_wstrb_q;
    logic [31:0] lat_wdata_q;
    logic [SW-1:0] streak_q;
    logic [31:0] inst_rdata_q, data_rdata_q;
    logic        inst_done_q, data_done_q, data_err_q;

    logic        grant_inst, grant_data, misalign_hit, data_capture;
    logic [3:0]  sa_wstrb;
    logic [31:0] sa_wdata;
    logic        sa_misaligned;

    sram_bus_arbiter_store_align u_store_align (
        .size          (data_size),
        .addr_lo       (data_addr[1:0]),
        .wr            (data_wr),
        .wdata         (data_wdata),
        .wstrb         (sa_wstrb),
        .wdata_aligned (sa_wdata),
        .misaligned    (sa_misaligned)
    );

    // Next-state and grant decision
    always_comb begin
        state_d      = state_q;
        grant_inst   = 1'b0;
        grant_data   = 1'b0;
        misalign_hit = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                // During a done cycle the finishing requester still holds req.
                // That req is stale and must not start a second transfer.
                if (!(inst_done_q || data_done_q)) begin
                    if (data_req && !(inst_req && (streak_q == STREAK_MAX))) begin
                        if (sa_misaligned) begin
                            misalign_hit = 1'b1;
                        end else begin
                            grant_data = 1'b1;
                            state_d    = ARB_ADDR;
                        end
                    end else if (inst_req) begin
                        grant_inst = 1'b1;
                        state_d    = ARB_ADDR;
                    end
                end
            end
            ARB_ADDR: begin
                if (bus_addr_ok) state_d = ARB_DATA;
            end
            ARB_DATA: begin
                if (bus_data_ok) state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign data_capture = (state_q == ARB_DATA) && bus_data_ok;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_INST;
            lat_addr_q   <= '0;
            lat_wr_q     <= 1'b0;
            lat_size_q   <= '0;
            lat_wstrb_q  <= '0;
            lat_wdata_q  <= '0;
            streak_q     <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            data_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            inst_done_q <= data_capture && (owner_q == OWN_INST);
            data_done_q <= (data_capture && (owner_q == OWN_DATA)) || misalign_hit;
            data_err_q  <= misalign_hit;

            if (grant_data) begin
                owner_q     <= OWN_DATA;
                lat_addr_q  <= data_addr;
                lat_wr_q    <= data_wr;
                lat_size_q  <= data_size;
                lat_wstrb_q <= sa_wstrb;
                lat_wdata_q <= sa_wdata;
                // The streak counts only the grants that make a fetch wait.
                if (inst_req) begin
                    if (streak_q != STREAK_MAX) streak_q <= streak_q + SW'(1);
                end else begin
                    streak_q <= '0;
                end
            end else if (grant_inst) begin
                owner_q     <= OWN_INST;
                lat_addr_q  <= inst_addr;
                lat_wr_q    <= 1'b0;
                lat_size_q  <= SZ_WORD;
                lat_wstrb_q <= 4'b0000;
                lat_wdata_q <= '0;
                streak_q    <= '0;
            end

            if (data_capture) begin
                if (owner_q == OWN_INST) inst_rdata_q <= bus_rdata;
                else                     data_rdata_q <= bus_rdata;
            end
        end
    end

    assign bus_req    = (state_q == ARB_ADDR);
    assign bus_wr     = lat_wr_q;
    assign bus_size   = lat_size_q;
    assign bus_addr   = lat_addr_q;
    assign bus_wstrb  = lat_wstrb_q;
    assign bus_wdata  = lat_wdata_q;

    assign inst_rdata = inst_rdata_q;
    assign inst_done  = inst_done_q;
    assign data_rdata = data_rdata_q;
    assign data_done  = data_done_q;
    assign data_err   = data_err_q;

    assign stallreq   = (inst_req & ~inst_done_q) | (data_req & ~data_done_q);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
module tb_sram_bus_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_done;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        data_err;
  logic        stallreq;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic [1:0]  dbg_state;

  sram_bus_arbiter #(.MAX_DATA_STREAK(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_done(inst_done),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_done(data_done), .data_err(data_err),
    .stallreq(stallreq),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_inst_rd;
  logic [31:0] exp_data_rd;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model for store formatting, written directly from the size rules.
  function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [3:0] ref_wstrb(input logic wr, input logic [1:0] sz, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (!wr) return 4'd0;
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return 4'(3 << off);
    return 4'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_data(input string nm, input logic wr, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ew, input logic [31:0] ewd, input logic eerr,
                         input int alat, input int dlat, input logic [31:0] rd, input logic spur);
    data_req = 1'b1; data_wr = wr; data_size = sz; data_addr = addr; data_wdata = wd;
    #1;
    chk($sformatf("%s stallreq", nm), 32'(stallreq), 32'd1);
    tick();
    if (eerr) begin
      chk($sformatf("%s no bus_req", nm), 32'(bus_req), 32'd0);
      chk($sformatf("%s err done", nm), 32'(data_done), 32'd1);
      chk($sformatf("%s data_err", nm), 32'(data_err), 32'd1);
      data_req = 1'b0;
      tick();
      chk($sformatf("%s done drop", nm), 32'({data_done, data_err, bus_req}), 32'd0);
    end else begin
      chk($sformatf("%s bus_req", nm), 32'(bus_req), 32'd1);
      chk($sformatf("%s bus_addr", nm), bus_addr, addr);
      chk($sformatf("%s bus_wr", nm), 32'(bus_wr), 32'(wr));
      chk($sformatf("%s bus_size", nm), 32'(bus_size), 32'(sz));
      chk($sformatf("%s bus_wstrb", nm), 32'(bus_wstrb), 32'(ew));
      chk($sformatf("%s bus_wdata", nm), bus_wdata, ewd);
      for (int i = 0; i < alat; i++) begin
        bus_data_ok = spur ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        chk($sformatf("%s addr hold req", nm), 32'(bus_req), 32'd1);
        chk($sformatf("%s addr hold addr", nm), bus_addr, addr);
        chk($sformatf("%s addr hold wdata", nm), bus_wdata, ewd);
        chk($sformatf("%s addr hold done", nm), 32'(data_done), 32'd0);
      end
      bus_data_ok = 1'b0;
      bus_addr_ok = 1'b1;
      tick();
      bus_addr_ok = 1'b0;
      chk($sformatf("%s req drop", nm), 32'(bus_req), 32'd0);
      for (int i = 0; i < dlat; i++) begin
        tick();
        chk($sformatf("%s data wait done", nm), 32'(data_done), 32'd0);
      end
      bus_data_ok = 1'b1; bus_rdata = rd;
      tick();
      bus_data_ok = 1'b0; bus_rdata = $urandom;
      exp_data_rd = rd;
      chk($sformatf("%s data_done", nm), 32'(data_done), 32'd1);
      chk($sformatf("%s data_err", nm), 32'(data_err), 32'd0);
      chk($sformatf("%s data_rdata", nm), data_rdata, exp_data_rd);
      chk($sformatf("%s inst_done", nm), 32'(inst_done), 32'd0);
      data_req = 1'b0;
      tick();
      chk($sformatf("%s done pulse", nm), 32'(data_done), 32'd0);
    end
    chk($sformatf("%s inst_rdata hold", nm), inst_rdata, exp_inst_rd);
  endtask

  task automatic do_inst(input string nm, input logic [31:0] addr, input int alat,
                         input int dlat, input logic [31:0] rd);
    inst_req = 1'b1; inst_addr = addr;
    tick();
    chk($sformatf("%s bus_req", nm), 32'(bus_req), 32'd1);
    chk($sformatf("%s bus_addr", nm), bus_addr, addr);
    chk($sformatf("%s fetch attrs", nm), 32'({bus_wr, bus_size, bus_wstrb}), 32'({1'b0, 2'd2, 4'd0}));
    for (int i = 0; i < alat; i++) tick();
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    for (int i = 0; i < dlat; i++) begin
      tick();
      chk($sformatf("%s wait done", nm), 32'(inst_done), 32'd0);
    end
    bus_data_ok = 1'b1; bus_rdata = rd;
    tick();
    bus_data_ok = 1'b0;
    exp_inst_rd = rd;
    chk($sformatf("%s inst_done", nm), 32'(inst_done), 32'd1);
    chk($sformatf("%s inst_rdata", nm), inst_rdata, exp_inst_rd);
    chk($sformatf("%s data_done", nm), 32'(data_done), 32'd0);
    chk($sformatf("%s data_rdata hold", nm), data_rdata, exp_data_rd);
    inst_req = 1'b0;
    tick();
    chk($sformatf("%s done pulse", nm), 32'(inst_done), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check_all_zero(input string nm);
    chk($sformatf("%s bus", nm), 32'({bus_req, bus_wr, bus_size, bus_wstrb}), 32'd0);
    chk($sformatf("%s bus_addr", nm), bus_addr, 32'd0);
    chk($sformatf("%s bus_wdata", nm), bus_wdata, 32'd0);
    chk($sformatf("%s flags", nm), 32'({inst_done, data_done, data_err, stallreq}), 32'd0);
    chk($sformatf("%s inst_rdata", nm), inst_rdata, 32'd0);
    chk($sformatf("%s data_rdata", nm), data_rdata, 32'd0);
    chk($sformatf("%s state", nm), 32'(dbg_state), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int ngrant;
    logic acked;
    logic seen_done;
    logic [31:0] e;

    resetn = 1'b0; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_wr = 1'b0;
    data_size = '0; data_addr = '0; data_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    exp_inst_rd = '0; exp_data_rd = '0;
    repeat (3) tick();
    resetn = 1'b1;
    check_all_zero("reset");

    vecs[0] = '{1'b0, 2'd2, 32'h0000_1000, 32'h1234_5678, 32'hDEAD_BEEF, 4'b0000, 32'h1234_5678, 1'b0};
    vecs[1] = '{1'b1, 2'd0, 32'h0000_2003, 32'h0000_00A5, 32'h1111_1111, 4'b1000, 32'hA5A5_A5A5, 1'b0};
    vecs[2] = '{1'b1, 2'd0, 32'h0000_2000, 32'h1234_5677, 32'h2222_2222, 4'b0001, 32'h7777_7777, 1'b0};
    vecs[3] = '{1'b1, 2'd1, 32'h0000_2002, 32'hFFFF_BEEF, 32'h3333_3333, 4'b1100, 32'hBEEF_BEEF, 1'b0};
    vecs[4] = '{1'b1, 2'd1, 32'h0000_2000, 32'h0000_CAFE, 32'h4444_4444, 4'b0011, 32'hCAFE_CAFE, 1'b0};
    vecs[5] = '{1'b1, 2'd2, 32'h0000_2004, 32'h0BAD_F00D, 32'h5555_5555, 4'b1111, 32'h0BAD_F00D, 1'b0};
    vecs[6] = '{1'b1, 2'd1, 32'h0000_3001, 32'h0000_1234, 32'h0, 4'b0000, 32'h0, 1'b1};
    vecs[7] = '{1'b0, 2'd2, 32'h0000_1002, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1};
    vecs[8] = '{1'b1, 2'd3, 32'h0000_4000, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1};
    vecs[9] = '{1'b0, 2'd0, 32'h0000_5001, 32'h0000_0000, 32'h6666_0066, 4'b0000, 32'h0000_0000, 1'b0};

    // Minimum latency: no bus wait states on any vector.
    for (int i = 0; i < 10; i++)
      do_data($sformatf("vec%0d", i), vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_wstrb, vecs[i].exp_wdata, vecs[i].exp_err, 0, 0, vecs[i].rdata, 1'b0);

    do_inst("fetch0", 32'h0000_0100, 0, 0, 32'h2402_0001);

    // addr_ok held off 4 cycles with spurious data_ok pulses during ADDR.
    do_data("slow_addr", 1'b1, 2'd0, 32'h0000_7002, 32'h0000_003C, 4'b0100, 32'h3C3C_3C3C,
            1'b0, 4, 2, 32'hCAFE_0001, 1'b1);

    // Arbitration: both requesters continuously asserted.
    exp_q = {32'd1, 32'd1, 32'd0, 32'd1, 32'd1, 32'd0};
    inst_addr = 32'h0000_0100; data_addr = 32'h0000_2000; data_wr = 1'b0; data_size = 2'd2;
    inst_req = 1'b1; data_req = 1'b1; acked = 1'b0; ngrant = 0;
    for (int cyc = 0; cyc < 60 && ngrant < 6; cyc++) begin
      #1;
      chk("arb stallreq", 32'(stallreq), 32'd1);
      tick();
      if (bus_req) begin
        e = exp_q.pop_front();
        chk($sformatf("arb grant%0d owner_is_data", ngrant), 32'(bus_addr == 32'h0000_2000), e);
        ngrant++;
      end
      bus_addr_ok = bus_req; bus_data_ok = acked; acked = bus_req;
    end
    chk("arb grant count", 32'(ngrant), 32'd6);
    data_req = 1'b0;
    seen_done = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick();
      if (inst_done) begin seen_done = 1'b1; inst_req = 1'b0; end
      bus_addr_ok = bus_req; bus_data_ok = acked; acked = bus_req;
    end
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    chk("arb last inst done", 32'(seen_done), 32'd1);
    chk("arb back to idle", 32'(dbg_state), 32'd0);
    exp_inst_rd = inst_rdata;  // bus_rdata held unchanged across the arbitration run
    exp_data_rd = data_rdata;
    chk("arb no stall after drop", 32'(stallreq), 32'd0);

    // Reset while in DATA, followed by a late data_ok.
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_6000;
    tick();
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    chk("rst in DATA", 32'(dbg_state), 32'd2);
    resetn = 1'b0; data_req = 1'b0;
    tick();
    resetn = 1'b1;
    check_all_zero("rst mid");
    bus_data_ok = 1'b1; bus_rdata = 32'hBAD0_BAD0;
    tick();
    bus_data_ok = 1'b0;
    tick();
    chk("rst late data_ok", 32'({inst_done, data_done, bus_req}), 32'd0);
    chk("rst rdata stays", data_rdata, 32'd0);
    exp_inst_rd = '0; exp_data_rd = '0;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [1:0] sz;
      logic [31:0] a, wd;
      logic w;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom; wd = $urandom; w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        do_inst($sformatf("rnd%0d_if", n), {a[31:2], 2'b00}, $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom);
      else
        do_data($sformatf("rnd%0d", n), w, sz, a, wd, ref_wstrb(w, sz, a), ref_wdata(sz, wd),
                ref_err(sz, a), $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
